// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter core: start, LSB-first data, parity, stop
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx_core #(
    parameter int DATA_WIDTH   = `DATA_WIDTH,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  TX_CLK,
    input  logic                  TX_RST,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  TX_OUT,
    output logic                  TX_BUSY
);

    localparam int   CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int   IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_out_q, tx_out_d;

    logic                    bit_end;
    logic                    ready;
    logic                    accept;

    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign ready    = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign accept   = TX_VALID && ready;

    assign TX_READY = ready;
    assign TX_OUT   = tx_out_q;
    assign TX_BUSY  = (state_q != IDLE);

    // State, counters and the registered serial line; reset aborts any frame at once
    always_ff @(posedge TX_CLK or posedge TX_RST) begin
        if (TX_RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_out_q <= tx_out_d;
        end
    end

    // Next state; tx_out_d is the line level for the bit the next cycle belongs to
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_out_d = tx_out_q;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                tx_out_d = 1'b1;
                if (accept) begin
                    state_d  = START;
                    idx_d    = '0;
                    shift_d  = TX_DATA;
                    par_d    = (^TX_DATA) ^ PAR_INV;
                    tx_out_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = DATA;
                    tx_out_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d  = PARITY;
                        tx_out_d = par_q;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        tx_out_d = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (accept) begin
                        // Back-to-back frame: start bit follows the stop bit directly
                        state_d  = START;
                        idx_d    = '0;
                        shift_d  = TX_DATA;
                        par_d    = (^TX_DATA) ^ PAR_INV;
                        tx_out_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                tx_out_d = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (uart_params.vh, 8), payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, TX_CLK cycles per serial bit; legal range >= 2.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; port names are TX_CLK and TX_RST.
REQ-005 TX_CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 TX_RST  input  1  asynchronous, active-high reset.
REQ-007 TX_DATA  input  DATA_WIDTH  payload word; sampled only on the accept edge.
REQ-008 TX_VALID  input  1  payload present request.
REQ-009 TX_READY  output  1  block can accept a word this cycle.
REQ-010 TX_OUT  output  1  serial line; idle high.
REQ-011 TX_BUSY  output  1  frame in progress (any state other than IDLE).

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_WIDTH data bits LSB first, one parity bit, one stop bit (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions: IDLE->START on accept; START->DATA; DATA->PARITY after DATA_WIDTH bits; PARITY->STOP; STOP->IDLE, or STOP->START if accept occurs in last STOP cycle.
REQ-015 Each non-IDLE bit SHALL hold TX_OUT stable for exactly CLKS_PER_BIT cycles, timed by a bit counter of width clog2(CLKS_PER_BIT).
REQ-016 Accept SHALL occur on a rising edge where TX_VALID=1 and TX_READY=1; TX_DATA SHALL be loaded into an internal shift register at that edge.
REQ-017 TX_READY SHALL be 1 in IDLE and in the final cycle of STOP, 0 otherwise.
REQ-018 TX_VALID while TX_READY=0 SHALL be ignored, with no effect on state or data; TX_DATA changes after accept SHALL not affect the frame in flight.
REQ-019 Latency: TX_OUT SHALL go low the cycle after the accept edge.
REQ-020 A single frame SHALL last exactly (DATA_WIDTH+3)*CLKS_PER_BIT cycles; back-to-back accepts SHALL produce frames with no idle gap.
REQ-021 Parity bit SHALL be XOR of the latched data word, inverted when PARITY_ODD=1.
REQ-022 TX_OUT SHALL be registered, with no combinational path from inputs.
REQ-023 In IDLE, TX_OUT SHALL be 1 and the bit counter SHALL be held at 0.

Reset
REQ-024 While TX_RST=1: state=IDLE, TX_OUT=1, TX_READY=1, TX_BUSY=0, counters=0, shift register=0.
REQ-025 Reset assertion mid-frame SHALL abort the frame immediately (asynchronously), with TX_OUT=1 and no partial bit resumed.
REQ-026 The first accept SHALL be possible on the first rising edge after TX_RST deasserts.

Verification
REQ-027 Single frame, CLKS_PER_BIT=4, PARITY_ODD=0, TX_DATA=8'hA5 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles, 44 cycles total; TX_BUSY=1 for exactly those cycles.
REQ-028 PARITY_ODD=1, TX_DATA=8'h07 -> parity bit 0; TX_DATA=8'h03 -> parity bit 1.
REQ-029 TX_VALID held high with 8'h55 then 8'hAA -> two consecutive 44-cycle frames; TX_READY pulses for one cycle at the end of each stop bit; no idle cycle between frames.
REQ-030 TX_VALID pulsed and TX_DATA toggled during a frame -> in-flight frame unchanged; no extra frame is sent.
REQ-031 TX_RST asserted during DATA bit 3 -> TX_OUT=1 and TX_READY=1 in the same cycle; a subsequent accept of 8'h3C sends a complete correct frame.
